// File: rtl/ritc_bit_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ritc_bit_align_ctrl
// Brief    : Automatic bit-alignment trainer for one RITC input lane.
//            Sweeps every IDELAY tap while the RITC sends its training word,
//            keeps the widest stable eye, loads the eye centre and then
//            bitslips the ISERDES until word framing matches.
//            Optional error monitor: define RITC_BIT_ALIGN_ERRMON_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ritc_bit_align_ctrl #(
  parameter int                      SERDES_WIDTH  = 4,
  parameter int                      DELAY_BITS    = 5,
  parameter logic [SERDES_WIDTH-1:0] TRAIN_PATTERN = 4'b0011,
  parameter int                      SAMPLE_BITS   = 8,
  parameter int                      SETTLE_CYCLES = 8,
  parameter int                      MIN_EYE       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [SERDES_WIDTH-1:0] serdes_i,
  output logic [DELAY_BITS-1:0]   delay_o,
  output logic                    load_o,
  output logic                    bitslip_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [DELAY_BITS-1:0]   eye_start_o,
  output logic [DELAY_BITS:0]     eye_width_o,
  input  logic                    monitor_i,
  output logic [15:0]             err_count_o
);

  // Counter wide enough for both the settle wait and the sample window
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W    = ((SAMPLE_BITS > SETTLE_W) ? SAMPLE_BITS : SETTLE_W) + 1;
  localparam int SLIP_W   = $clog2(SERDES_WIDTH) + 1;
  localparam int LEN_W    = DELAY_BITS + 1;

  localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SAMPLE_LAST = CNT_W'((1 << SAMPLE_BITS) - 1);
  localparam logic [DELAY_BITS-1:0] TAP_LAST    = {DELAY_BITS{1'b1}};
  localparam logic [SLIP_W-1:0]     SLIP_LAST   = SLIP_W'(SERDES_WIDTH - 1);
  localparam logic [LEN_W-1:0]      MIN_LEN     = LEN_W'(MIN_EYE);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_SETTLE  = 4'd2,
    S_SAMPLE  = 4'd3,
    S_NEXT    = 4'd4,
    S_CENTER  = 4'd5,
    S_CSETTLE = 4'd6,
    S_CHECK   = 4'd7,
    S_SLIP    = 4'd8,
    S_SWAIT   = 4'd9,
    S_DONE    = 4'd10,
    S_FAIL    = 4'd11
  } state_t;

  state_t                  state_q, state_d;
  logic [DELAY_BITS-1:0]   tap_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SLIP_W-1:0]       slip_q;
  logic [SERDES_WIDTH-1:0] ref_q;
  logic                    stable_q;
  logic [DELAY_BITS-1:0]   run_start_q;
  logic [LEN_W-1:0]        run_len_q;
  logic [DELAY_BITS-1:0]   best_start_q;
  logic [LEN_W-1:0]        best_len_q;
  logic [DELAY_BITS-1:0]   eye_start_q;
  logic [LEN_W-1:0]        eye_width_q;
  logic [DELAY_BITS-1:0]   delay_q;

  logic                    w_start_accept;
  logic                    w_eye_ok;
  logic [DELAY_BITS-1:0]   w_center;
  logic [DELAY_BITS-1:0]   w_load_val;
  logic [LEN_W-1:0]        w_new_len;
  logic [DELAY_BITS-1:0]   w_new_start;
  logic                    w_close;

  // True when the word equals TRAIN_PATTERN under some rotation
  function automatic logic is_rotation(input logic [SERDES_WIDTH-1:0] word);
    logic [SERDES_WIDTH-1:0] rot;
    logic                    hit;
    rot = TRAIN_PATTERN;
    hit = 1'b0;
    for (int i = 0; i < SERDES_WIDTH; i++) begin
      if (word == rot) hit = 1'b1;
      rot = {rot[0], rot[SERDES_WIDTH-1:1]};
    end
    return hit;
  endfunction

  assign w_start_accept = start_i &&
                          ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
  assign w_eye_ok       = (best_len_q >= MIN_LEN);
  assign w_center       = best_start_q + DELAY_BITS'(best_len_q >> 1);
  assign w_load_val     = (state_q == S_CENTER) ? w_center : tap_q;

  // Run extension seen at the end of each tap; the last tap always closes the run
  assign w_new_len   = stable_q ? (run_len_q + LEN_W'(1)) : run_len_q;
  assign w_new_start = (stable_q && (run_len_q == '0)) ? tap_q : run_start_q;
  assign w_close     = !stable_q || (tap_q == TAP_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_d   = state_q;
    load_o    = 1'b0;
    bitslip_o = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    fail_o    = 1'b0;
    delay_o   = delay_q;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_o  = 1'b1;
        delay_o = w_load_val;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) state_d = S_NEXT;
      end
      S_NEXT: begin
        state_d = (tap_q == TAP_LAST) ? S_CENTER : S_LOAD;
      end
      S_CENTER: begin
        if (w_eye_ok) begin
          load_o  = 1'b1;
          delay_o = w_load_val;
          state_d = S_CSETTLE;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_CSETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (serdes_i == TRAIN_PATTERN) state_d = S_DONE;
        else if (slip_q == SLIP_LAST)  state_d = S_FAIL;
        else                           state_d = S_SLIP;
      end
      S_SLIP: begin
        bitslip_o = 1'b1;
        state_d   = S_SWAIT;
      end
      S_SWAIT: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
        if (start_i) state_d = S_LOAD;
      end
      S_FAIL: begin
        busy_o = 1'b0;
        fail_o = 1'b1;
        if (start_i) state_d = S_LOAD;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sweep datapath: tap/cycle counters, stability check, run tracking, eye latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap_q        <= '0;
      cnt_q        <= '0;
      slip_q       <= '0;
      ref_q        <= '0;
      stable_q     <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      eye_start_q  <= '0;
      eye_width_q  <= '0;
      delay_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (w_start_accept) begin
            tap_q        <= '0;
            cnt_q        <= '0;
            slip_q       <= '0;
            ref_q        <= '0;
            stable_q     <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            eye_start_q  <= '0;
            eye_width_q  <= '0;
          end
        end
        S_SETTLE, S_CSETTLE, S_SWAIT: begin
          cnt_q <= (cnt_q == SETTLE_LAST) ? '0 : (cnt_q + CNT_W'(1));
        end
        S_SAMPLE: begin
          cnt_q <= (cnt_q == SAMPLE_LAST) ? '0 : (cnt_q + CNT_W'(1));
          if (cnt_q == '0) begin
            ref_q    <= serdes_i;
            stable_q <= is_rotation(serdes_i);
          end else if (serdes_i != ref_q) begin
            stable_q <= 1'b0;
          end
        end
        S_NEXT: begin
          if (w_close) begin
            // Strict compare: an equal-length later run never displaces the earlier one
            if (w_new_len > best_len_q) begin
              best_start_q <= w_new_start;
              best_len_q   <= w_new_len;
            end
            run_len_q <= '0;
          end else begin
            run_start_q <= w_new_start;
            run_len_q   <= w_new_len;
          end
          if (tap_q != TAP_LAST) tap_q <= tap_q + DELAY_BITS'(1);
        end
        S_CENTER: begin
          if (w_eye_ok) begin
            eye_start_q <= best_start_q;
            eye_width_q <= best_len_q;
          end
        end
        S_SLIP: begin
          slip_q <= slip_q + SLIP_W'(1);
        end
        default: begin
        end
      endcase
      // Remember the last value handed to the IDELAY so delay_o holds it
      if (load_o) delay_q <= w_load_val;
    end
  end

  assign eye_start_o = eye_start_q;
  assign eye_width_o = eye_width_q;

`ifdef RITC_BIT_ALIGN_ERRMON_EN
  logic [15:0] err_q;

  // Saturating count of framing mismatches while trained and monitoring
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else if (w_start_accept) begin
      err_q <= '0;
    end else if ((state_q == S_DONE) && monitor_i &&
                 (serdes_i != TRAIN_PATTERN) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count_o = err_q;
`else
  logic w_unused_monitor;
  assign w_unused_monitor = monitor_i;
  assign err_count_o      = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/ritc_bit_align_ctrl.md
Name: ritc_bit_align_ctrl

Overview:
- Parametrised successor to the per-bit control for the RITC input path.
- Automatically trains one input lane; no host-driven delay or bitslip writes.
- Sweeps all IDELAY taps while the RITC sends a training pattern, finds the widest stable eye and loads its centre tap.
- Then bitslips the ISERDES until word framing matches. Sits beside each lane's IDELAYE2/ISERDESE2, clocked in the SERDES divided-clock domain.

Parameters:
- SERDES_WIDTH, 4, ISERDES word width (serdes_i width, maximum slips before failure).
- DELAY_BITS, 5, IDELAY tap value width; the sweep covers 0 to 2^DELAY_BITS-1.
- TRAIN_PATTERN, 4'b0011, correctly framed training word (SERDES_WIDTH bits; all rotations must be distinct).
- SAMPLE_BITS, 8, 2^SAMPLE_BITS words sampled per tap.
- SETTLE_CYCLES, 8, wait after each load_o or bitslip_o pulse before sampling.
- MIN_EYE, 4, minimum stable-run length for success.

Ports:
- clk_i  in  1  SERDES divided clock (DATACLK_DIV2 domain).
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse starting training.
- serdes_i  in  SERDES_WIDTH  ISERDES Q word.
- delay_o  out  DELAY_BITS  IDELAY CNTVALUEIN.
- load_o  out  1  IDELAY LD pulse.
- bitslip_o  out  1  ISERDES BITSLIP pulse.
- busy_o  out  1  training in progress.
- done_o  out  1  trained successfully (sticky).
- fail_o  out  1  training failed (sticky).
- eye_start_o  out  DELAY_BITS  first tap of the chosen eye.
- eye_width_o  out  DELAY_BITS+1  chosen eye length in taps.
- monitor_i  in  1  enables the error monitor (optional feature).
- err_count_o  out  16  mismatch count (optional feature).

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-training aborts on the next edge. The IDELAY is not reloaded until the next load_o.
- start_i behaviour:
  - Accepted in IDLE, DONE or FAIL.
  - On acceptance: clears done_o, fail_o, eye registers and run trackers; sets busy_o next cycle.
  - Ignored while busy_o is high.
- States: IDLE -> LOAD -> SETTLE -> SAMPLE -> NEXT -> (LOAD | CENTER) -> CSETTLE -> CHECK -> (SLIP -> SWAIT -> CHECK) -> DONE | FAIL.
- LOAD: delay_o = tap and load_o = 1 for exactly one cycle, on the same cycle.
- SETTLE: SETTLE_CYCLES cycles.
- SAMPLE: 2^SAMPLE_BITS cycles.
  - First word is the reference word.
  - The tap is stable iff every word equals the reference and the reference is a rotation of TRAIN_PATTERN.
- NEXT run tracking:
  - Stable tap: extend the current run (start = tap if the run is empty).
  - Unstable tap: close the run.
  - Closing a run: replace best if its length > best length (strict; ties keep the earlier run).
  - After tap 2^DELAY_BITS-1, close the open run and go to CENTER. Tap counters do not wrap into a second pass.
- CENTER:
  - If best length < MIN_EYE: go to FAIL.
  - Otherwise delay_o = best_start + floor(best_len/2), pulse load_o, and latch eye_start_o/eye_width_o.
  - CSETTLE waits SETTLE_CYCLES.
- CHECK: if serdes_i == TRAIN_PATTERN, go to DONE.
  - Else if the slip count equals SERDES_WIDTH-1, go to FAIL.
  - Else pulse bitslip_o for one cycle (SLIP), increment the slip count, and wait SETTLE_CYCLES (SWAIT).
- DONE / FAIL:
  - busy_o = 0; done_o or fail_o = 1 and held until start_i or rst_i.
  - delay_o holds its last loaded value.
- Per-tap time: 1 + SETTLE_CYCLES + 2^SAMPLE_BITS + 1 cycles.

Optional Feature:
- Macro: RITC_BIT_ALIGN_ERRMON_EN.
- Defined:
  - In DONE with monitor_i = 1, each cycle where serdes_i != TRAIN_PATTERN increments err_count_o.
  - err_count_o saturates at 16'hFFFF and is cleared by rst_i or an accepted start_i.
- Undefined: err_count_o is tied to 0, monitor_i is ignored, and no counter logic is built.

Test Plan:
- Defaults; bench lane model stable on taps 9..20, pattern rotated by 2 -> delay_o = 15, one load_o pulse per tap plus one for the centre, exactly 2 bitslip_o pulses, done_o = 1, eye_start_o = 9, eye_width_o = 12.
- Stable runs 2..5 and 20..23 (equal length 4) -> eye_start_o = 2, delay_o = 4, done_o = 1.
- Stable only on taps 30..31 (length 2 < MIN_EYE) -> fail_o = 1, no bitslip_o pulses, busy_o falls.
- Stable taps 0..31 but the word never matches any slip position -> 3 bitslip_o pulses, then fail_o = 1.
- rst_i asserted during SAMPLE at tap 7 -> next cycle all outputs 0, state IDLE; start_i restarts the sweep at tap 0; start_i while busy_o = 1 has no effect.
- With RITC_BIT_ALIGN_ERRMON_EN, after DONE, monitor_i = 1 and 5 corrupted words -> err_count_o = 5; a new start_i clears it to 0.
